// File: rtl/alu_defs.sv
// alu_defs: ALUSel encodings shared by the combinational ALU, the decoder
// and the iterative multiplier. It also holds the multiplier state
// encoding and a small op-classification helper.
package alu_defs;

  // Combinational ALU operations
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_SUB    = 4'b1100;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_BSEL   = 4'b1111;

  // RV32M multiply codes; the whole 10xx block belongs to mul_unit
  localparam logic [3:0] ALU_MUL    = 4'b1000;
  localparam logic [3:0] ALU_MULH   = 4'b1001;
  localparam logic [3:0] ALU_MULHSU = 4'b1010;
  localparam logic [3:0] ALU_MULHU  = 4'b1011;

  // Multiplier control states
  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_CALC = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // True for any select code handled by the multiplier
  function automatic logic is_mul_op(input logic [3:0] sel);
    return (sel[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for mul/mulh/mulhsu/mulhu.
// Operands are converted to magnitudes at capture, multiplied one
// multiplier bit per cycle (LSB first) and the sign is applied on the
// final edge, so latency is fixed at N cycles regardless of operand values.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   A, B            - rs1 / rs2 operands (N bits)
//   ALUSel          - operation select (10xx handled here)
//   in_valid/ready  - operation handshake; ready only in IDLE
//   out_valid/ready - result handshake; Res held until taken
//   Res             - registered N-bit result
module mul_unit
  import alu_defs::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   ALUSel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Res
);

  localparam int CW = $clog2(N) + 1;

  mul_state_e     state_r;
  mul_state_e     state_nxt_s;

  logic [2*N-1:0] mcand_r;     // multiplicand, pre-shifted to the current bit
  logic [N-1:0]   mplier_r;    // multiplier, shifted right so bit 0 is current
  logic [2*N-1:0] acc_r;
  logic [CW-1:0]  cnt_r;
  logic           neg_r;
  logic           hi_r;
  logic [N-1:0]   res_r;
  logic           out_valid_r;

  logic           accept_s;
  logic           a_signed_s;
  logic           b_signed_s;
  logic           a_neg_s;
  logic           b_neg_s;
  logic [N-1:0]   a_mag_s;
  logic [N-1:0]   b_mag_s;
  logic           last_s;
  logic [2*N-1:0] acc_sum_s;
  logic [2*N-1:0] prod_s;

  assign in_ready  = (state_r == MUL_IDLE);
  assign out_valid = out_valid_r;
  assign Res       = res_r;

  assign accept_s = in_valid && (state_r == MUL_IDLE) && is_mul_op(ALUSel);
  assign last_s   = (cnt_r == CW'(N - 1));

  // Operand signedness and magnitudes; -2^(N-1) negates to itself, which
  // is the correct unsigned magnitude 2^(N-1).
  always_comb begin
    a_signed_s = (ALUSel[1:0] != 2'b11);
    b_signed_s = (ALUSel[1] == 1'b0);
    a_neg_s    = a_signed_s && A[N-1];
    b_neg_s    = b_signed_s && B[N-1];
    if (a_neg_s) begin
      a_mag_s = (~A) + N'(1);
    end else begin
      a_mag_s = A;
    end
    if (b_neg_s) begin
      b_mag_s = (~B) + N'(1);
    end else begin
      b_mag_s = B;
    end
  end

  // Partial-product step and final sign application of the full product
  always_comb begin
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
    if (neg_r) begin
      prod_s = (~acc_sum_s) + (2*N)'(1);
    end else begin
      prod_s = acc_sum_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MUL_IDLE: begin
        if (accept_s) begin
          state_nxt_s = MUL_CALC;
        end else begin
          state_nxt_s = MUL_IDLE;
        end
      end
      MUL_CALC: begin
        if (last_s) begin
          state_nxt_s = MUL_DONE;
        end else begin
          state_nxt_s = MUL_CALC;
        end
      end
      MUL_DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = MUL_IDLE;
        end else begin
          state_nxt_s = MUL_DONE;
        end
      end
      default: state_nxt_s = MUL_IDLE;
    endcase
  end

  // Datapath: capture, iterate, publish the selected half, hand off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      neg_r       <= 1'b0;
      hi_r        <= 1'b0;
      res_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (accept_s) begin
            mcand_r  <= {{N{1'b0}}, a_mag_s};
            mplier_r <= b_mag_s;
            acc_r    <= '0;
            cnt_r    <= '0;
            neg_r    <= a_neg_s ^ b_neg_s;
            hi_r     <= (ALUSel[1:0] != 2'b00);
          end else begin
            cnt_r    <= cnt_r;
          end
        end
        MUL_CALC: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= {mcand_r[2*N-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[N-1:1]};
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            res_r       <= hi_r ? prod_s[2*N-1:N] : prod_s[N-1:0];
            out_valid_r <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        MUL_DONE: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: self-checking bench for mul_unit. Expected results come
// from a 64-bit arithmetic model of the RV32M multiply semantics.
module tb_mul_unit;
  import alu_defs::*;

  localparam int N = 32;

  logic          clk;
  logic          rst;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [3:0]    ALUSel;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  Res;

  int checks;
  int errors;

  mul_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUSel(ALUSel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .Res(Res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: sign/zero-extend to 64 bits, multiply modulo 2^64, pick half
  function automatic logic [31:0] model_mul(input logic [3:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (sel == ALU_MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
    eb = (sel == ALU_MUL || sel == ALU_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (sel == ALU_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Starts at the negedge after capture; counts edges until out_valid
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); lat++; @(negedge clk);
    end
    if (in_ready !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int lat;
    int hold;
    logic busy_ok;
    exp = model_mul(sel, a, b);
    @(negedge clk);
    ALUSel = sel; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_before: got %b want 1", tag, in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat, busy_ok);
    checks++;
    if (lat !== N) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, N);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_busy: got high want low", tag);
    end
    checks++;
    if (Res !== exp) begin
      errors++; $display("FAIL %s result: got %h want %h (a=%h b=%h sel=%b)", tag, Res, exp, a, b, sel);
    end
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || Res !== exp) begin
        errors++; $display("FAIL %s hold: got v=%b r=%h want v=1 r=%h", tag, out_valid, Res, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s handoff: got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUSel = ALU_ADD;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || Res !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset: got v=%b r=%h rdy=%b want 0/0/1", out_valid, Res, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(ALU_MUL,    32'h00000007, 32'hFFFFFFFD, "mul_7_m3");
    do_op(ALU_MULH,   32'h80000000, 32'h80000000, "mulh_min");
    do_op(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
    do_op(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    do_op(ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, "mul_m1_m1");
    do_op(ALU_MULH,   32'h7FFFFFFF, 32'h80000000, "mulh_maxmin");
    do_op(ALU_MULHSU, 32'h80000000, 32'hFFFFFFFF, "mulhsu_min");
  endtask

  task automatic test_random();
    logic [31:0] corner [4];
    logic [31:0] a, b;
    logic [3:0] sel;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h80000000; corner[3] = 32'hFFFFFFFF;
    for (int i = 0; i < 24; i++) begin
      sel = 4'b1000 | 4'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
      do_op(sel, a, b, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp;
    int lat;
    logic busy_ok;
    a = 32'($urandom); b = 32'($urandom);
    exp = model_mul(ALU_MUL, a, b);
    @(negedge clk);
    ALUSel = ALU_MUL; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat, busy_ok);
    checks++;
    if (Res !== exp) begin
      errors++; $display("FAIL bp_result: got %h want %h", Res, exp);
    end
    for (int i = 0; i < 5; i++) begin
      A = 32'($urandom); B = 32'($urandom); ALUSel = ALU_MULHU;
      in_valid = (i % 2 == 0);
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || Res !== exp || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall: got v=%b r=%h rdy=%b want v=1 r=%h rdy=0", out_valid, Res, in_ready, exp);
      end
    end
    A = 32'd3; B = 32'd5; ALUSel = ALU_MUL; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_queued_accept: got rdy=%b want 0", in_ready);
    end
    wait_done(lat, busy_ok);
    checks++;
    if (lat !== N || Res !== 32'd15) begin
      errors++; $display("FAIL bp_queued_result: got lat=%0d r=%h want lat=%0d r=0000000f", lat, Res, N);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    ALUSel = ALU_MUL; A = 32'($urandom) | 32'h1; B = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Res !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_calc: got v=%b r=%h rdy=%b want 0/0/1", out_valid, Res, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(ALU_MUL, 32'd3, 32'd5, "after_reset");
  endtask

  task automatic test_illegal_sel();
    logic [3:0] sel;
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) sel = 4'b0000;
      else if (i == 1) sel = 4'b1111;
      else sel = 4'($urandom_range(0, 15));
      if (sel[3:2] == 2'b10) sel = 4'b1111;
      ALUSel = sel; A = 32'($urandom); B = 32'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) bad = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL illegal_sel: got state change want none");
    end
  endtask

  task automatic test_back_to_back();
    int k, lat1, cap2, lat2;
    logic seen1, busy_ok;
    logic [31:0] r1;
    @(negedge clk);
    ALUSel = ALU_MUL; A = 32'h0; B = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    k = 0; seen1 = 1'b0; cap2 = -1; lat1 = -1; r1 = 32'hx;
    @(negedge clk);
    A = 32'h0000FFFF; B = 32'h0000FFFF;
    while (cap2 < 0 && k < 100) begin
      if (out_valid === 1'b1 && !seen1) begin
        seen1 = 1'b1; lat1 = k; r1 = Res;
      end
      if (in_ready === 1'b1) cap2 = k + 1;
      @(posedge clk); k++; @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done(lat2, busy_ok);
    checks++;
    if (lat1 !== N || r1 !== 32'h0) begin
      errors++; $display("FAIL b2b_first: got lat=%0d r=%h want lat=%0d r=00000000", lat1, r1, N);
    end
    checks++;
    if (cap2 !== N + 2) begin
      errors++; $display("FAIL b2b_interval: got %0d want %0d", cap2, N + 2);
    end
    checks++;
    if (lat2 !== N || Res !== 32'hFFFE0001) begin
      errors++; $display("FAIL b2b_second: got lat=%0d r=%h want lat=%0d r=fffe0001", lat2, Res, N);
    end
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_illegal_sel();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
